// File: rtl/el2_ifu_parcel_aligner.sv
// Fetch-word to instruction aligner: halfword queue, compressed expansion hand-off, PC tracking.
// Optional pop statistics counters are enabled by defining RV_ALIGN_STATS_EN.
module el2_ifu_parcel_aligner #(
  parameter int QDEPTH = 6,
  parameter int PCW    = 31
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fetch_valid,
  output logic           fetch_ready,
  input  logic [31:0]    fetch_data,
  input  logic           flush,
  input  logic [PCW-1:0] flush_pc,
  output logic [15:0]    exp_din,
  input  logic [31:0]    exp_dout,
  output logic           instr_valid,
  input  logic           instr_ready,
  output logic [31:0]    instr,
  output logic           instr_is16,
  output logic [15:0]    instr_raw16,
  output logic           instr_illegal,
  output logic [PCW-1:0] instr_pc
`ifdef RV_ALIGN_STATS_EN
  ,
  output logic [15:0]    stat_c16,
  output logic [15:0]    stat_c32
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  // Handshakes: a transfer happens on a side only in a cycle where its
  // valid and ready are both high; ready never depends on same-cycle pops.
  logic [15:0]    q [QDEPTH];
  ptr_t           wrptr, rdptr;
  logic [CW-1:0]  cnt;
  logic           drop_low;
  logic [PCW-1:0] pc_q;

  function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(QDEPTH)) s = s - (PW+1)'(QDEPTH);
    return s[PW-1:0];
  endfunction

  ptr_t        rd1, wr1;
  logic [15:0] h0, h1;
  logic        have1, have2, is_c, head_valid, push, pop;
  logic [1:0]  n_push, n_pop;

  assign rd1   = ptr_add(rdptr, 2'd1);
  assign wr1   = ptr_add(wrptr, 2'd1);
  assign h0    = q[rdptr];
  assign h1    = q[rd1];
  assign have1 = (cnt != '0);
  assign have2 = (cnt >= CW'(2));
  assign is_c  = (h0[1:0] != 2'b11);

  assign head_valid  = !rst && have1 && (is_c || have2);
  assign fetch_ready = !rst && !flush && (cnt <= CW'(QDEPTH - 2));
  assign push        = fetch_valid && fetch_ready;
  assign pop         = head_valid && instr_ready && !flush;
  assign n_push      = push ? (drop_low ? 2'd1 : 2'd2) : 2'd0;
  assign n_pop       = pop ? (is_c ? 2'd1 : 2'd2) : 2'd0;
  assign instr_pc    = pc_q;

  always_comb begin
    exp_din       = '0;
    instr_valid   = 1'b0;
    instr         = '0;
    instr_is16    = 1'b0;
    instr_raw16   = '0;
    instr_illegal = 1'b0;
    if (!rst && have1) exp_din = h0;
    if (head_valid) begin
      instr_valid = 1'b1;
      if (is_c) begin
        instr         = exp_dout;
        instr_is16    = 1'b1;
        instr_raw16   = h0;
        instr_illegal = (exp_dout == 32'h0);
      end else begin
        instr = {h1, h0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      wrptr    <= '0;
      rdptr    <= '0;
      drop_low <= 1'b0;
      pc_q     <= '0;
    end else if (flush) begin
      cnt      <= '0;
      wrptr    <= '0;
      rdptr    <= '0;
      drop_low <= flush_pc[0];
      pc_q     <= flush_pc;
    end else begin
      cnt   <= cnt + CW'(n_push) - CW'(n_pop);
      wrptr <= ptr_add(wrptr, n_push);
      rdptr <= ptr_add(rdptr, n_pop);
      pc_q  <= pc_q + PCW'(n_pop);
      if (push) drop_low <= 1'b0;
    end
  end

  // Queue storage is never reset; cnt alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      if (drop_low) begin
        q[wrptr] <= fetch_data[31:16];
      end else begin
        q[wrptr] <= fetch_data[15:0];
        q[wr1]   <= fetch_data[31:16];
      end
    end
  end

`ifdef RV_ALIGN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_c16 <= '0;
      stat_c32 <= '0;
    end else if (pop) begin
      if (is_c) begin
        if (stat_c16 != 16'hFFFF) stat_c16 <= stat_c16 + 16'd1;
      end else begin
        if (stat_c32 != 16'hFFFF) stat_c32 <= stat_c32 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_el2_ifu_parcel_aligner.sv
// Bench for el2_ifu_parcel_aligner: directed vector table plus random traffic
// checked against a halfword-queue reference model.
module tb_el2_ifu_parcel_aligner;

  localparam int QDEPTH = 6;
  localparam int PCW    = 31;

  logic           clk = 1'b0;
  logic           rst;
  logic           fetch_valid;
  logic           fetch_ready;
  logic [31:0]    fetch_data;
  logic           flush;
  logic [PCW-1:0] flush_pc;
  logic [15:0]    exp_din;
  logic [31:0]    exp_dout;
  logic           instr_valid;
  logic           instr_ready;
  logic [31:0]    instr;
  logic           instr_is16;
  logic [15:0]    instr_raw16;
  logic           instr_illegal;
  logic [PCW-1:0] instr_pc;
`ifdef RV_ALIGN_STATS_EN
  logic [15:0]    stat_c16, stat_c32;
`endif

  int checks   = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Stub expander: zero parcel is illegal, anything else gets a recognisable pattern.
  function automatic logic [31:0] stub(input logic [15:0] p);
    return (p == 16'h0) ? 32'h0 : {~p, p};
  endfunction
  assign exp_dout = stub(exp_din);

  el2_ifu_parcel_aligner #(.QDEPTH(QDEPTH), .PCW(PCW)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .flush(flush), .flush_pc(flush_pc),
    .exp_din(exp_din), .exp_dout(exp_dout),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_is16(instr_is16), .instr_raw16(instr_raw16), .instr_illegal(instr_illegal),
    .instr_pc(instr_pc)
`ifdef RV_ALIGN_STATS_EN
    , .stat_c16(stat_c16), .stat_c32(stat_c32)
`endif
  );

  // ---------------- reference model ----------------
  logic [15:0]    mq[$];
  logic [PCW-1:0] m_pc;
  bit             m_drop;
  int             m_c16, m_c32;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit             fv;
    logic [31:0]    fd;
    bit             ir;
    bit             fl;
    logic [PCW-1:0] fpc;
    bit             e_fr;
    bit             e_v;
    bit             e_is16;
    logic [15:0]    e_raw;
    logic [31:0]    e_instr;
    bit             e_ill;
    logic [PCW-1:0] e_pc;
  } vec_t;

  // Compare every output against the model, then advance the model across the edge.
  task automatic model_cycle(input string tag);
    bit          e_fr, e_v, e_is16, e_ill;
    logic [15:0] e_raw, e_din;
    logic [31:0] e_instr;
    int          sz;
    sz      = mq.size();
    e_fr    = !flush && ((QDEPTH - sz) >= 2);
    e_v     = 0; e_is16 = 0; e_ill = 0; e_raw = '0; e_instr = '0;
    e_din   = (sz >= 1) ? mq[0] : 16'h0;
    if (sz >= 1 && mq[0][1:0] != 2'b11) begin
      e_v = 1; e_is16 = 1; e_raw = mq[0]; e_instr = stub(mq[0]); e_ill = (e_instr == 0);
    end else if (sz >= 2) begin
      e_v = 1; e_instr = {mq[1], mq[0]};
    end
    chk({tag, " fetch_ready"}, 32'(fetch_ready), 32'(e_fr));
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'(e_v));
    chk({tag, " instr"}, instr, e_instr);
    chk({tag, " instr_is16"}, 32'(instr_is16), 32'(e_is16));
    chk({tag, " instr_raw16"}, 32'(instr_raw16), 32'(e_raw));
    chk({tag, " instr_illegal"}, 32'(instr_illegal), 32'(e_ill));
    chk({tag, " instr_pc"}, 32'(instr_pc), 32'(m_pc));
    chk({tag, " exp_din"}, 32'(exp_din), 32'(e_din));
`ifdef RV_ALIGN_STATS_EN
    chk({tag, " stat_c16"}, 32'(stat_c16), 32'(m_c16));
    chk({tag, " stat_c32"}, 32'(stat_c32), 32'(m_c32));
`endif
    if (flush) begin
      mq.delete();
      m_pc   = flush_pc;
      m_drop = flush_pc[0];
    end else begin
      if (e_v && instr_ready) begin
        if (e_is16) begin
          void'(mq.pop_front()); m_pc = m_pc + 1;
          if (m_c16 < 65535) m_c16++;
        end else begin
          void'(mq.pop_front()); void'(mq.pop_front()); m_pc = m_pc + 2;
          if (m_c32 < 65535) m_c32++;
        end
      end
      if (fetch_valid && e_fr) begin
        if (!m_drop) mq.push_back(fetch_data[15:0]);
        mq.push_back(fetch_data[31:16]);
        m_drop = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit fv, input logic [31:0] fd, input bit ir,
                       input bit fl, input logic [PCW-1:0] fpc);
    fetch_valid = fv; fetch_data = fd; instr_ready = ir; flush = fl; flush_pc = fpc;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0, '0);
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset fetch_ready", 32'(fetch_ready), 32'h0);
    chk("reset instr_valid", 32'(instr_valid), 32'h0);
    chk("reset exp_din", 32'(exp_din), 32'h0);
    chk("reset instr", instr, 32'h0);
    chk("reset instr_pc", 32'(instr_pc), 32'h0);
    rst = 0;
    mq.delete(); m_pc = '0; m_drop = 0; m_c16 = 0; m_c32 = 0;
  endtask

  function automatic vec_t v(bit fv, logic [31:0] fd, bit ir, bit fl, logic [PCW-1:0] fpc,
                             bit fr, bit vl, bit is16, logic [15:0] raw, logic [31:0] ins,
                             bit ill, logic [PCW-1:0] pc);
    vec_t r;
    r.fv = fv; r.fd = fd; r.ir = ir; r.fl = fl; r.fpc = fpc;
    r.e_fr = fr; r.e_v = vl; r.e_is16 = is16; r.e_raw = raw; r.e_instr = ins;
    r.e_ill = ill; r.e_pc = pc;
    return r;
  endfunction

  vec_t tbl[21];

  initial begin
    // two c.li, straddled addi, illegal zero parcel, backpressure, half-aligned flush
    tbl[0]  = v(1, 32'h4501_4505, 1, 0, '0,      1, 0, 0, 16'h0,    32'h0,         0, 31'd0);
    tbl[1]  = v(0, 32'h0,         1, 0, '0,      1, 1, 1, 16'h4505, 32'hBAFA_4505, 0, 31'd0);
    tbl[2]  = v(0, 32'h0,         1, 0, '0,      1, 1, 1, 16'h4501, 32'hBAFE_4501, 0, 31'd1);
    tbl[3]  = v(0, 32'h0,         1, 0, '0,      1, 0, 0, 16'h0,    32'h0,         0, 31'd2);
    tbl[4]  = v(1, 32'h0093_4505, 1, 0, '0,      1, 0, 0, 16'h0,    32'h0,         0, 31'd2);
    tbl[5]  = v(0, 32'h0,         1, 0, '0,      1, 1, 1, 16'h4505, 32'hBAFA_4505, 0, 31'd2);
    tbl[6]  = v(1, 32'h0000_0010, 1, 0, '0,      1, 0, 0, 16'h0,    32'h0,         0, 31'd3);
    tbl[7]  = v(0, 32'h0,         1, 0, '0,      1, 1, 0, 16'h0,    32'h0010_0093, 0, 31'd3);
    tbl[8]  = v(0, 32'h0,         1, 0, '0,      1, 1, 1, 16'h0,    32'h0,         1, 31'd5);
    tbl[9]  = v(1, 32'h2222_1111, 0, 0, '0,      1, 0, 0, 16'h0,    32'h0,         0, 31'd6);
    tbl[10] = v(1, 32'h4444_5555, 0, 0, '0,      1, 1, 1, 16'h1111, 32'hEEEE_1111, 0, 31'd6);
    tbl[11] = v(1, 32'h6666_9999, 0, 0, '0,      1, 1, 1, 16'h1111, 32'hEEEE_1111, 0, 31'd6);
    tbl[12] = v(1, 32'h8888_CCCC, 0, 0, '0,      0, 1, 1, 16'h1111, 32'hEEEE_1111, 0, 31'd6);
    tbl[13] = v(1, 32'h8888_CCCC, 1, 0, '0,      0, 1, 1, 16'h1111, 32'hEEEE_1111, 0, 31'd6);
    tbl[14] = v(1, 32'h8888_CCCC, 1, 0, '0,      0, 1, 1, 16'h2222, 32'hDDDD_2222, 0, 31'd7);
    tbl[15] = v(1, 32'h8888_CCCC, 1, 0, '0,      1, 1, 1, 16'h5555, 32'hAAAA_5555, 0, 31'd8);
    tbl[16] = v(0, 32'h0,         1, 0, '0,      0, 1, 1, 16'h4444, 32'hBBBB_4444, 0, 31'd9);
    tbl[17] = v(1, 32'hDEAD_BEEF, 1, 1, 31'h801, 0, 1, 1, 16'h9999, 32'h6666_9999, 0, 31'd10);
    tbl[18] = v(1, 32'hA001_0001, 1, 0, '0,      1, 0, 0, 16'h0,    32'h0,         0, 31'h801);
    tbl[19] = v(0, 32'h0,         1, 0, '0,      1, 1, 1, 16'hA001, 32'h5FFE_A001, 0, 31'h801);
    tbl[20] = v(0, 32'h0,         1, 0, '0,      1, 0, 0, 16'h0,    32'h0,         0, 31'h802);

    do_reset();

    for (int i = 0; i < 21; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].fv, tbl[i].fd, tbl[i].ir, tbl[i].fl, tbl[i].fpc);
      #3;
      chk({tag, " fetch_ready"}, 32'(fetch_ready), 32'(tbl[i].e_fr));
      chk({tag, " instr_valid"}, 32'(instr_valid), 32'(tbl[i].e_v));
      chk({tag, " instr_is16"}, 32'(instr_is16), 32'(tbl[i].e_is16));
      chk({tag, " instr_raw16"}, 32'(instr_raw16), 32'(tbl[i].e_raw));
      chk({tag, " instr"}, instr, tbl[i].e_instr);
      chk({tag, " instr_illegal"}, 32'(instr_illegal), 32'(tbl[i].e_ill));
      chk({tag, " instr_pc"}, 32'(instr_pc), 32'(tbl[i].e_pc));
      model_cycle({tag, " model"});
      @(posedge clk); #1;
    end

    // Random traffic; half of the parcels look like 32-bit lower halves.
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] lo, hi;
      if (c == 1500) do_reset();
      lo = 16'($urandom); hi = 16'($urandom);
      if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) hi[1:0] = 2'b11;
      if ($urandom_range(0, 15) == 0) lo = 16'h0;
      drive($urandom_range(0, 3) != 0, {hi, lo}, $urandom_range(0, 3) != 0,
            $urandom_range(0, 40) == 0, PCW'($urandom));
      #3;
      model_cycle($sformatf("rnd%0d", c));
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
